micro_decode_table: RTL
=======================

Name: micro_decode_table

Overview:
- Runtime-programmable, parametrised decoder from instruction pattern to micro command, for the NPC decode stage.
- Each entry has a pattern, a care-mask and a micro command, so "funct3 don't-care" is a per-entry mask.
- Lookup sits behind one registered valid/ready stage and uses lowest-index priority.
- Adds multi-hit detection, a saturating miss counter, and a config write port for patching or extending the instruction set without re-synthesis.

Parameters:
- PATTERN_LEN, 8: lookup key width, format {funct3[2:0], opcode[6:2]}.
- MICRO_LEN, 10: micro command width, format {regen, pcjen, pcren, mwen[1:0], mren[1:0], imm_type[2:0]}.
- ENTRY_NR, 16: table depth; must be at least 6 so the default entries fit.
- IDX_W, $clog2(ENTRY_NR): entry index width.
- CNT_W, 16: miss counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  stage can accept a request.
- in_inst  in  PATTERN_LEN  lookup key.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_micro  out  MICRO_LEN  micro command; zero on miss.
- out_hit  out  1  at least one entry matched.
- out_multi  out  1  more than one entry matched (error flag).
- out_idx  out  IDX_W  index of the winning entry; zero on miss.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  entry to write.
- cfg_en  in  1  entry valid bit to write.
- cfg_pattern  in  PATTERN_LEN  pattern to write.
- cfg_mask  in  PATTERN_LEN  care-mask to write; 1 = bit compared.
- cfg_micro  in  MICRO_LEN  micro command to write.
- miss_clr  in  1  clear the miss counter.
- miss_cnt  out  CNT_W  saturating count of accepted misses.

Behaviour:
- Match rule: entry i matches when en[i] && ((in_inst ^ pattern[i]) & mask[i]) == 0.
- Priority: the lowest matching index wins. out_micro is that entry's micro command, not an OR of all matches.
- Multi-hit: out_multi = 1 when the popcount of matches is at least 2. Data still follows the lowest-index entry.
- Handshake: in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready.
  - Latency is exactly 1 cycle: the result registers appear with out_valid = 1 on the next edge.
  - If out_valid && !out_ready, all out_* are held stable and no request is accepted.
  - If there is no accept and out_ready = 1, out_valid drops to 0 on the next edge.
  - Back-to-back accepts give full throughput.
- Config write: when cfg_we = 1, the entry at cfg_idx is updated on the edge.
  - A lookup accepted in the same cycle uses the old contents; the write is visible from the next cycle.
  - A held output is never modified by a write.
  - cfg_idx >= ENTRY_NR: the write is ignored.
- Miss counter: increments on each accepted lookup with no match and saturates at all-ones.
  - miss_clr takes priority over an increment in the same cycle; the result is 0.
- Reset (async on rst_n low, synchronously released):
  - out_valid = 0, out_micro = 0, out_hit = 0, out_multi = 0, out_idx = 0, miss_cnt = 0, in_ready = 1.
  - Table entries 0-5 load the package defaults. Entries 6 and up load en = 0, pattern = 0, mask = 0, micro = 0.
  - Reset mid-transaction drops any held result.
- Package defaults, each as pattern / mask / micro:
  - 0 AUIPC: 000_00101 / 000_11111 / 1_0_1_00_00_110
  - 1 JAL: 000_11011 / 000_11111 / 1_1_1_00_00_111
  - 2 JALR: 000_11001 / 000_11111 / 1_1_0_00_00_001
  - 3 SW: 010_01000 / 111_11111 / 0_0_0_11_00_010
  - 4 ADDI: 000_00100 / 000_11111 / 1_0_0_00_00_001
  - 5 EBREAK: 000_11100 / 000_11111 / all zero
- No $display on miss; misses are reported only through out_hit and miss_cnt.

Decomposition:
- Shared package decode_pkg:
  - micro field constants (REGEN_*, PCJEN_*, PCREN_*, MWEN_*, MREN_*, IMM_TYPE_*);
  - a packed struct for the micro command;
  - an entry struct {en, pattern, mask, micro};
  - the default entry array DEFAULT_ENTRIES[6].
- One sub-module, decode_match_prio: combinational match vector, priority encoder, popcount-at-least-2 detector. Parametrised by ENTRY_NR, with outputs hit, multi and idx.
- Table registers, pipeline stage and counter stay in the top level.

Test Plan:
- Reset, then in_inst = 8'b000_00101 with out_ready = 1 -> next cycle out_valid = 1, out_hit = 1, out_idx = 0, out_micro = 10'b1010000110.
- in_inst = 8'b111_00100 (ANDI) -> idx 4, out_micro = 10'b1000000001, because funct3 is masked out.
- in_inst = 8'b000_01100 three times, then miss_clr asserted together with a fourth miss -> out_hit = 0 and out_micro = 0 on each; miss_cnt reads 1, 2, 3, then 0.
- Write entry 7 = {1, 000_00100, 111_11111, 10'h3FF} in the same cycle as an ADDI lookup -> that result has idx 4, multi = 0. The next ADDI lookup gives out_multi = 1, idx 4.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs stable. When out_ready rises, the next inst is accepted that cycle and its result appears on the following edge.
- Assert rst_n = 0 while out_valid = 1 -> out_valid = 0 immediately (asynchronous). Entry 7 reverts to en = 0, and miss_cnt = 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types, micro-command field encodings and reset-time table contents
// for the instruction-pattern to micro-command decoder.
package decode_pkg;

   localparam int unsigned PATTERN_LEN = 8;
   localparam int unsigned MICRO_LEN   = 10;
   localparam int unsigned DEFAULT_NR  = 6;

   localparam logic REGEN_OFF = 1'b0;
   localparam logic REGEN_ON  = 1'b1;
   localparam logic PCJEN_OFF = 1'b0;
   localparam logic PCJEN_ON  = 1'b1;
   localparam logic PCREN_OFF = 1'b0;
   localparam logic PCREN_ON  = 1'b1;

   localparam logic [1:0] MWEN_NONE = 2'b00;
   localparam logic [1:0] MWEN_WORD = 2'b11;
   localparam logic [1:0] MREN_NONE = 2'b00;
   localparam logic [1:0] MREN_WORD = 2'b11;

   localparam logic [2:0] IMM_TYPE_NONE = 3'b000;
   localparam logic [2:0] IMM_TYPE_I    = 3'b001;
   localparam logic [2:0] IMM_TYPE_S    = 3'b010;
   localparam logic [2:0] IMM_TYPE_U    = 3'b110;
   localparam logic [2:0] IMM_TYPE_J    = 3'b111;

   typedef struct packed {
      logic       regen;
      logic       pcjen;
      logic       pcren;
      logic [1:0] mwen;
      logic [1:0] mren;
      logic [2:0] imm_type;
   } micro_t;

   typedef struct packed {
      logic                   en;
      logic [PATTERN_LEN-1:0] pattern;
      logic [PATTERN_LEN-1:0] mask;
      micro_t                 micro;
   } entry_t;

   // Key layout is {funct3, opcode[6:2]}; a zero funct3 mask means "any funct3".
   localparam entry_t DEFAULT_ENTRIES [DEFAULT_NR] = '{
      '{1'b1, 8'b000_00101, 8'b000_11111,                             // AUIPC
        '{REGEN_ON,  PCJEN_OFF, PCREN_ON,  MWEN_NONE, MREN_NONE, IMM_TYPE_U}},
      '{1'b1, 8'b000_11011, 8'b000_11111,                             // JAL
        '{REGEN_ON,  PCJEN_ON,  PCREN_ON,  MWEN_NONE, MREN_NONE, IMM_TYPE_J}},
      '{1'b1, 8'b000_11001, 8'b000_11111,                             // JALR
        '{REGEN_ON,  PCJEN_ON,  PCREN_OFF, MWEN_NONE, MREN_NONE, IMM_TYPE_I}},
      '{1'b1, 8'b010_01000, 8'b111_11111,                             // SW
        '{REGEN_OFF, PCJEN_OFF, PCREN_OFF, MWEN_WORD, MREN_NONE, IMM_TYPE_S}},
      '{1'b1, 8'b000_00100, 8'b000_11111,                             // ADDI
        '{REGEN_ON,  PCJEN_OFF, PCREN_OFF, MWEN_NONE, MREN_NONE, IMM_TYPE_I}},
      '{1'b1, 8'b000_11100, 8'b000_11111,                             // EBREAK
        '{REGEN_OFF, PCJEN_OFF, PCREN_OFF, MWEN_NONE, MREN_NONE, IMM_TYPE_NONE}}
   };

   // Reset contents for any table slot; slots beyond the defaults come up empty.
   function automatic entry_t default_entry(input int unsigned idx);
      entry_t e;
      e = '0;
      if (idx < DEFAULT_NR) begin
         e = DEFAULT_ENTRIES[idx];
      end
      return e;
   endfunction

endpackage

// File: rtl/decode_match_prio.sv
// Combinational table search: per-entry masked compare, lowest-index
// priority encode and a two-or-more-hits detector.
module decode_match_prio
   import decode_pkg::*;
#(
   parameter int unsigned ENTRY_NR    = 16,
   parameter int unsigned PATTERN_LEN = decode_pkg::PATTERN_LEN,
   parameter int unsigned IDX_W       = $clog2(ENTRY_NR)
) (
   input  logic [PATTERN_LEN-1:0] inst,
   input  logic [ENTRY_NR-1:0]    en,
   input  logic [PATTERN_LEN-1:0] pattern [ENTRY_NR],
   input  logic [PATTERN_LEN-1:0] mask    [ENTRY_NR],
   output logic                   hit,
   output logic                   multi,
   output logic [IDX_W-1:0]       idx
);

   logic [ENTRY_NR-1:0] match;

   // Masked compare of the key against every enabled entry
   always_comb begin
      match = '0;
      for (int i = 0; i < ENTRY_NR; i++) begin
         match[i] = en[i] && (((inst ^ pattern[i]) & mask[i]) == '0);
      end
   end

   // First hit claims idx; any later hit flags a multi-match
   always_comb begin
      hit   = 1'b0;
      multi = 1'b0;
      idx   = '0;
      for (int i = 0; i < ENTRY_NR; i++) begin
         if (match[i]) begin
            if (hit) begin
               multi = 1'b1;
            end else begin
               idx = IDX_W'(i);
            end
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/micro_decode_table.sv
// Runtime-programmable decode table behind a single registered valid/ready
// stage, with a config write port and a saturating miss counter.
module micro_decode_table
   import decode_pkg::*;
#(
   parameter int unsigned PATTERN_LEN = decode_pkg::PATTERN_LEN,
   parameter int unsigned MICRO_LEN   = decode_pkg::MICRO_LEN,
   parameter int unsigned ENTRY_NR    = 16,  // at least DEFAULT_NR
   parameter int unsigned IDX_W       = $clog2(ENTRY_NR),
   parameter int unsigned CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PATTERN_LEN-1:0] in_inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MICRO_LEN-1:0]   out_micro,
   output logic                   out_hit,
   output logic                   out_multi,
   output logic [IDX_W-1:0]       out_idx,
   input  logic                   cfg_we,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic                   cfg_en,
   input  logic [PATTERN_LEN-1:0] cfg_pattern,
   input  logic [PATTERN_LEN-1:0] cfg_mask,
   input  logic [MICRO_LEN-1:0]   cfg_micro,
   input  logic                   miss_clr,
   output logic [CNT_W-1:0]       miss_cnt
);

   logic [ENTRY_NR-1:0]    tbl_en;
   logic [PATTERN_LEN-1:0] tbl_pattern [ENTRY_NR];
   logic [PATTERN_LEN-1:0] tbl_mask    [ENTRY_NR];
   logic [MICRO_LEN-1:0]   tbl_micro   [ENTRY_NR];

   // Table storage. Out-of-range cfg_idx never equals any slot index, so such
   // writes fall through untouched.
   for (genvar g = 0; g < ENTRY_NR; g++) begin : gen_entry
      localparam entry_t RstEntry = default_entry(g);

      logic                   en_q;
      logic [PATTERN_LEN-1:0] pattern_q;
      logic [PATTERN_LEN-1:0] mask_q;
      logic [MICRO_LEN-1:0]   micro_q;

      // Entry register: package default on reset, overwritten by a config write
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            en_q      <= RstEntry.en;
            pattern_q <= PATTERN_LEN'(RstEntry.pattern);
            mask_q    <= PATTERN_LEN'(RstEntry.mask);
            micro_q   <= MICRO_LEN'(RstEntry.micro);
         end else if (cfg_we && (cfg_idx == IDX_W'(g))) begin
            en_q      <= cfg_en;
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
            micro_q   <= cfg_micro;
         end
      end

      assign tbl_en[g]      = en_q;
      assign tbl_pattern[g] = pattern_q;
      assign tbl_mask[g]    = mask_q;
      assign tbl_micro[g]   = micro_q;
   end

   logic             match_hit;
   logic             match_multi;
   logic [IDX_W-1:0] match_idx;

   decode_match_prio #(
      .ENTRY_NR    (ENTRY_NR),
      .PATTERN_LEN (PATTERN_LEN),
      .IDX_W       (IDX_W)
   ) u_match (
      .inst    (in_inst),
      .en      (tbl_en),
      .pattern (tbl_pattern),
      .mask    (tbl_mask),
      .hit     (match_hit),
      .multi   (match_multi),
      .idx     (match_idx)
   );

   logic                 valid_q;
   logic [MICRO_LEN-1:0] micro_q;
   logic                 hit_q;
   logic                 multi_q;
   logic [IDX_W-1:0]     idx_q;
   logic [CNT_W-1:0]     miss_cnt_q;
   logic [CNT_W-1:0]     miss_cnt_d;
   logic                 accept;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Result stage: capture on accept, drain when consumed, otherwise hold.
   // Lookup reads the pre-write table, so a same-cycle config write is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         micro_q <= '0;
         hit_q   <= 1'b0;
         multi_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         micro_q <= match_hit ? tbl_micro[match_idx] : '0;
         hit_q   <= match_hit;
         multi_q <= match_multi;
         idx_q   <= match_idx;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Miss counter next state: clear wins, increment saturates at all-ones
   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (miss_clr) begin
         miss_cnt_d = '0;
      end else if (accept && !match_hit && (miss_cnt_q != '1)) begin
         miss_cnt_d = miss_cnt_q + 1'b1;
      end
   end

   // Miss counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt_q <= '0;
      end else begin
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_micro = micro_q;
   assign out_hit   = hit_q;
   assign out_multi = multi_q;
   assign out_idx   = idx_q;
   assign miss_cnt  = miss_cnt_q;

endmodule
